// File: rtl/store_merge_unit.sv
// Sub-word store engine: SW goes straight to memory, SH/SB read the containing word,
// splice the narrow data into the addressed little-endian lane and write it back.
module store_merge_unit #(
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StoreReq,
    input  logic [1:0]  StoreOp,
    input  logic [31:0] StoreAddr,
    input  logic [31:0] StoreData,
    output logic        Busy,
    output logic        StoreDone,
    output logic        StoreErr,
    output logic [31:0] MemAddr,
    output logic        MemRE,
    output logic        MemWE,
    output logic [31:0] MemWD,
    input  logic [31:0] MemRD
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [1:0] OpSw = 2'b00;
    localparam logic [1:0] OpSh = 2'b01;
    localparam logic [1:0] OpSb = 2'b10;

    localparam logic [2:0] LatInit = 3'(READ_LAT);

    logic [2:0]  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        req_err;
    logic [31:0] merged;

    // Reserved op, misaligned word, or odd halfword address is rejected without memory access.
    always_comb begin
        req_err = 1'b0;
        unique case (StoreOp)
            OpSw:    req_err = (StoreAddr[1:0] != 2'b00);
            OpSh:    req_err = StoreAddr[0];
            OpSb:    req_err = 1'b0;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (StoreReq) begin
                    op_d   = StoreOp;
                    addr_d = StoreAddr;
                    data_d = StoreData;
                    err_d  = req_err;
                    if (req_err) begin
                        state_d = StDone;
                    end else if (StoreOp == OpSw) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                cnt_d   = LatInit;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    word_d  = MemRD;
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 2'b00;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
            word_q  <= 32'h0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        merged = word_q;
        unique case (op_q)
            OpSh: begin
                if (addr_q[1]) merged[31:16] = data_q[15:0];
                else           merged[15:0]  = data_q[15:0];
            end
            OpSb: begin
                unique case (addr_q[1:0])
                    2'd0:    merged[7:0]   = data_q[7:0];
                    2'd1:    merged[15:8]  = data_q[7:0];
                    2'd2:    merged[23:16] = data_q[7:0];
                    default: merged[31:24] = data_q[7:0];
                endcase
            end
            default: merged = data_q;
        endcase
    end

    always_comb begin
        Busy      = (state_q != StIdle);
        StoreDone = (state_q == StDone);
        StoreErr  = (state_q == StDone) && err_q;
        MemRE     = (state_q == StRead);
        MemWE     = (state_q == StWrite);
        MemAddr   = {addr_q[31:2], 2'b00};
        MemWD     = (state_q == StWrite) ? merged : 32'h0;
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (read latency 1 and 3) against a word-array
// memory model that returns valid data only in the capture cycle and garbage otherwise.
module tb_store_merge_unit;

    localparam int unsigned Lat0 = 1;
    localparam int unsigned Lat1 = 3;

    logic        clk = 1'b0;
    logic        reset     [2];
    logic        StoreReq  [2];
    logic [1:0]  StoreOp   [2];
    logic [31:0] StoreAddr [2];
    logic [31:0] StoreData [2];
    logic        Busy      [2];
    logic        StoreDone [2];
    logic        StoreErr  [2];
    logic [31:0] MemAddr   [2];
    logic        MemRE     [2];
    logic        MemWE     [2];
    logic [31:0] MemWD     [2];
    logic [31:0] MemRD     [2];

    logic [31:0] mem [2][16];
    int          rd_cnt  [2];
    logic [3:0]  rd_idx  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    store_merge_unit #(.READ_LAT(Lat0)) dut0 (
        .clk(clk), .reset(reset[0]), .StoreReq(StoreReq[0]), .StoreOp(StoreOp[0]),
        .StoreAddr(StoreAddr[0]), .StoreData(StoreData[0]), .Busy(Busy[0]),
        .StoreDone(StoreDone[0]), .StoreErr(StoreErr[0]), .MemAddr(MemAddr[0]),
        .MemRE(MemRE[0]), .MemWE(MemWE[0]), .MemWD(MemWD[0]), .MemRD(MemRD[0])
    );

    store_merge_unit #(.READ_LAT(Lat1)) dut1 (
        .clk(clk), .reset(reset[1]), .StoreReq(StoreReq[1]), .StoreOp(StoreOp[1]),
        .StoreAddr(StoreAddr[1]), .StoreData(StoreData[1]), .Busy(Busy[1]),
        .StoreDone(StoreDone[1]), .StoreErr(StoreErr[1]), .MemAddr(MemAddr[1]),
        .MemRE(MemRE[1]), .MemWE(MemWE[1]), .MemWD(MemWD[1]), .MemRD(MemRD[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? int'(Lat0) : int'(Lat1);
    endfunction

    // Memory read port: data is valid exactly READ_LAT cycles after the MemRE cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rd_cnt[d] > 0) rd_cnt[d] = rd_cnt[d] - 1;
            if (MemRE[d] === 1'b1) begin
                rd_cnt[d] = lat(d) + 1;
                rd_idx[d] = MemAddr[d][5:2];
            end
            MemRD[d] = (rd_cnt[d] == 1) ? mem[d][rd_idx[d]] : $urandom;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, " Busy"},      32'(Busy[d]),      32'h0);
        check({tag, " StoreDone"}, 32'(StoreDone[d]), 32'h0);
        check({tag, " StoreErr"},  32'(StoreErr[d]),  32'h0);
        check({tag, " MemRE"},     32'(MemRE[d]),     32'h0);
        check({tag, " MemWE"},     32'(MemWE[d]),     32'h0);
    endtask

    // Issues one request on instance d; poke_k > 0 pulses a stray StoreReq in cycle t+poke_k.
    task automatic run_store(input int d, input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input int poke_k, input string tag);
        int          l;
        bit          err;
        int          off;
        logic [31:0] old, mask, exp_wd, wd, re_addr, we_addr;
        int          re_k, we_k, done_k, nre, nwe, busy_low;
        logic        errflag;
        l   = lat(d);
        err = (op == 2'b11) || (op == 2'b00 && addr[1:0] != 2'b00) || (op == 2'b01 && addr[0]);
        off = int'(addr[1:0]);
        old = mem[d][addr[5:2]];
        case (op)
            2'b00:   exp_wd = data;
            2'b01: begin
                mask   = 32'h0000FFFF << (8 * off);
                exp_wd = (old & ~mask) | ((data & 32'h0000FFFF) << (8 * off));
            end
            default: begin
                mask   = 32'h000000FF << (8 * off);
                exp_wd = (old & ~mask) | ((data & 32'h000000FF) << (8 * off));
            end
        endcase
        re_k = -1; we_k = -1; done_k = -1; nre = 0; nwe = 0; busy_low = 0;
        errflag = 1'b0; wd = 32'h0; re_addr = 32'h0; we_addr = 32'h0;

        @(negedge clk);
        StoreReq[d]  = 1'b1;
        StoreOp[d]   = op;
        StoreAddr[d] = addr;
        StoreData[d] = data;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            StoreReq[d]  = (k == poke_k);
            StoreOp[d]   = 2'b00;
            StoreAddr[d] = $urandom & 32'hFFFF_FFFC;
            StoreData[d] = $urandom;
            if (MemRE[d] === 1'b1) begin nre++; re_k = k; re_addr = MemAddr[d]; end
            if (MemWE[d] === 1'b1) begin nwe++; we_k = k; we_addr = MemAddr[d]; wd = MemWD[d]; end
            if (Busy[d] !== 1'b1) busy_low++;
            if (StoreDone[d] === 1'b1) begin
                done_k  = k;
                errflag = StoreErr[d];
                break;
            end
        end
        StoreReq[d] = 1'b0;

        check({tag, " StoreErr"}, 32'(errflag), 32'(err));
        check({tag, " busy_gaps"}, 32'(busy_low), 32'h0);
        if (err) begin
            check({tag, " done_cycle"}, 32'(done_k), 32'd1);
            check({tag, " re_count"}, 32'(nre), 32'd0);
            check({tag, " we_count"}, 32'(nwe), 32'd0);
        end else if (op == 2'b00) begin
            check({tag, " done_cycle"}, 32'(done_k), 32'd2);
            check({tag, " re_count"}, 32'(nre), 32'd0);
            check({tag, " we_count"}, 32'(nwe), 32'd1);
            check({tag, " we_cycle"}, 32'(we_k), 32'd1);
        end else begin
            check({tag, " done_cycle"}, 32'(done_k), 32'(3 + l));
            check({tag, " re_count"}, 32'(nre), 32'd1);
            check({tag, " re_cycle"}, 32'(re_k), 32'd1);
            check({tag, " re_addr"}, re_addr, {addr[31:2], 2'b00});
            check({tag, " we_count"}, 32'(nwe), 32'd1);
            check({tag, " we_cycle"}, 32'(we_k), 32'(2 + l));
        end
        if (!err) begin
            check({tag, " we_addr"}, we_addr, {addr[31:2], 2'b00});
            check({tag, " MemWD"}, wd, exp_wd);
            mem[d][addr[5:2]] = exp_wd;
        end
        @(negedge clk);
        check({tag, " idle_after_busy"}, 32'(Busy[d]), 32'h0);
        check({tag, " single_done"}, 32'(StoreDone[d]), 32'h0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; StoreReq[d] = 1'b0; StoreOp[d] = 2'b00;
            StoreAddr[d] = 32'h0; StoreData[d] = 32'h0; MemRD[d] = 32'h0;
            rd_cnt[d] = 0; rd_idx[d] = 4'h0;
            for (int i = 0; i < 16; i++) mem[d][i] = $urandom;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d, "reset");
            check("reset MemAddr", MemAddr[d], 32'h0);
            check("reset MemWD", MemWD[d], 32'h0);
            reset[d] = 1'b0;
        end

        // Directed cases on the latency-1 instance.
        run_store(0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 0, "sw_0x10");
        mem[0][4] = 32'h1122_3344;
        run_store(0, 2'b10, 32'h0000_0013, 32'h0000_00AB, 0, "sb_0x13");
        check("sb_0x13 merged", mem[0][4], 32'hAB22_3344);
        mem[0][8] = 32'h5566_7788;
        run_store(0, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 0, "sh_0x22");
        check("sh_0x22 merged", mem[0][8], 32'hCAFE_7788);
        mem[0][8] = 32'h5566_7788;
        run_store(0, 2'b01, 32'h0000_0020, 32'h0000_CAFE, 0, "sh_0x20");
        check("sh_0x20 merged", mem[0][8], 32'h5566_CAFE);
        run_store(0, 2'b01, 32'h0000_0021, 32'h1234_5678, 0, "err_sh_odd");
        run_store(0, 2'b00, 32'h0000_0002, 32'h1234_5678, 0, "err_sw_mis");
        run_store(0, 2'b11, 32'h0000_0000, 32'h1234_5678, 0, "err_op11");

        // Latency-3 instance with a stray request while busy.
        mem[1][0] = 32'hFFFF_FFFF;
        run_store(1, 2'b10, 32'h0000_0000, 32'h0000_005A, 2, "sb_lat3");
        check("sb_lat3 merged", mem[1][0], 32'hFFFF_FF5A);

        // Reset while an SB sits in WAIT: the store must vanish without a write or done.
        @(negedge clk);
        StoreReq[1] = 1'b1; StoreOp[1] = 2'b10; StoreAddr[1] = 32'h0000_0008;
        StoreData[1] = 32'h0000_0077;
        @(negedge clk);
        StoreReq[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_reset Busy", 32'(Busy[1]), 32'h1);
        reset[1] = 1'b1;
        StoreReq[1] = 1'b1;
        StoreOp[1] = 2'b00;
        StoreAddr[1] = 32'h0000_0004;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle_outputs(1, "abort");
            check("abort MemAddr", MemAddr[1], 32'h0);
        end
        reset[1] = 1'b0;
        StoreReq[1] = 1'b0;
        begin
            int dones, writes;
            dones = 0; writes = 0;
            repeat (8) begin
                @(negedge clk);
                if (StoreDone[1] === 1'b1) dones++;
                if (MemWE[1] === 1'b1) writes++;
            end
            check("abort no_done", 32'(dones), 32'h0);
            check("abort no_write", 32'(writes), 32'h0);
        end
        run_store(1, 2'b10, 32'h0000_0009, 32'h0000_00C3, 0, "post_reset_sb");

        // Random stores on both instances against the array model.
        for (int i = 0; i < 40; i++) begin
            run_store(i % 2, 2'($urandom_range(0, 3)), $urandom, $urandom,
                      int'($urandom_range(0, 4)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Sub-word store engine for the multicycle MIPS datapath; it is the store-side counterpart of load-path extension. It takes a store request (SW/SH/SB) with a byte address and register data. For SH/SB it reads the containing word from word-wide data memory, replaces the addressed lane with the narrow data, and writes the merged word back. For SW it writes directly. It sits between the main control FSM / register-file write-data path and the data-memory port.

## Interface
- READ_LAT, 1: memory read latency in cycles from the MemRE cycle to valid MemRD; legal range 1..4.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- StoreReq  in  1  request strobe; sampled only in IDLE
- StoreOp  in  2  00 SW, 01 SH, 10 SB, 11 reserved
- StoreAddr  in  32  byte address
- StoreData  in  32  store data; SH uses [15:0], SB uses [7:0]
- Busy  out  1  high in every state except IDLE
- StoreDone  out  1  one-cycle completion pulse
- StoreErr  out  1  one-cycle pulse coincident with StoreDone on a rejected request
- MemAddr  out  32  word address {addr[31:2],2'b00}
- MemRE  out  1  one-cycle read strobe
- MemWE  out  1  one-cycle write strobe
- MemWD  out  32  write data, valid when MemWE=1
- MemRD  in  32  read data, valid READ_LAT cycles after the MemRE cycle

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE.
- Registered state holds op, addr, data, err flag, captured word, and a wait counter (width ≥ 3).
- Byte lane order is little-endian:
  - offset 0 → [7:0], 1 → [15:8], 2 → [23:16], 3 → [31:24].
  - SH offset 0 → [15:0], offset 2 → [31:16].
- IDLE: when StoreReq=1, latch StoreOp, StoreAddr, and StoreData. Then:
  - Error if op=11, if SW with addr[1:0]≠0, or if SH with addr[0]≠0. On error, go to DONE with err set and issue no memory access.
  - SW (valid) → WRITE.
  - SH/SB (valid) → READ.
- READ: MemRE=1 for exactly one cycle. Load the counter with READ_LAT. Go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter equals 1, capture MemRD into the word register and go to WRITE. WAIT therefore lasts exactly READ_LAT cycles.
- WRITE: MemWE=1 for exactly one cycle.
  - SW: MemWD = latched data.
  - SH/SB: MemWD = captured word with the addressed lane replaced; all other bits are unchanged.
- DONE: StoreDone=1, and StoreErr=err flag. Go to IDLE.
- MemAddr holds the latched word address from acceptance until the next acceptance. MemWD is don't-care when MemWE=0.
- StoreReq while Busy=1 is ignored, not queued. The controller must wait for StoreDone.
- MemRE and MemWE are never high in the same cycle. An SW never asserts MemRE.

## Timing
- Reset values: state IDLE; Busy, StoreDone, StoreErr, MemRE, and MemWE all 0; MemAddr and MemWD 0x00000000; counter 0.
- Request sampled at edge of cycle t (state IDLE):
  - SW: WRITE at t+1, DONE at t+2.
  - SH/SB: READ at t+1, WAIT at t+2..t+1+READ_LAT, WRITE at t+2+READ_LAT, DONE at t+3+READ_LAT.
  - Error: DONE with StoreErr at t+1.
- A new request can be accepted in the cycle after DONE. Back-to-back SW throughput is 1 per 3 cycles.
- Reset in any state: at the next edge, go to IDLE with all outputs at reset values. No MemWE occurs after the reset edge. In-flight read data is discarded, and no StoreDone is issued for the aborted request.
- Reset takes priority over StoreReq in the same cycle.
- MemRD is sampled only in the capture cycle. Changes at any other time have no effect.

## Test plan
- Reset: assert reset for 2 cycles while an SB is in WAIT → Busy=0, MemRE=0, MemWE=0, and no StoreDone afterwards. The next request then behaves normally.
- SW to addr 0x00000010 with data 0xDEADBEEF → at t+1, MemWE=1, MemAddr=0x10, MemWD=0xDEADBEEF, and MemRE never asserts. At t+2, StoreDone=1 and StoreErr=0.
- SB (READ_LAT=1) to addr 0x00000013 with data 0x000000AB, memory word 0x11223344 → MemRE at t+1 with MemAddr=0x10. At t+3, MemWE=1 and MemWD=0xAB223344. StoreDone at t+4.
- SH to addr 0x00000022 with data 0x0000CAFE, memory 0x55667788 → MemWD=0xCAFE7788. SH to 0x20 with the same memory → MemWD=0x5566CAFE.
- Errors: each of SH@0x21, SW@0x02, and op=11@0x0 → StoreDone=1 and StoreErr=1 at t+1, with no MemRE or MemWE in between.
- READ_LAT=3: SB to 0x0 with data 0x5A, memory 0xFFFFFFFF → MemRD is changed to garbage except in the capture cycle, giving MemWD=0xFFFFFF5A at t+5. A StoreReq pulsed at t+2 is ignored, and exactly one StoreDone occurs.
